// File: rtl/vedic_pkg.sv
// Shared types for the sequential Vedic multiplier: FSM states, quadrant
// index and the shift selection applied to each quadrant product.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    SH_ZERO = 2'd0,
    SH_HALF = 2'd1,
    SH_FULL = 2'd2
  } shift_t;

  localparam quad_t Q_LO_LO = 2'd0;
  localparam quad_t Q_LO_HI = 2'd1;
  localparam quad_t Q_HI_LO = 2'd2;
  localparam quad_t Q_HI_HI = 2'd3;

  // The two cross terms share the same HALF shift.
  function automatic shift_t quad_shift(input quad_t q);
    case (q)
      Q_LO_LO: quad_shift = SH_ZERO;
      Q_LO_HI: quad_shift = SH_HALF;
      Q_HI_LO: quad_shift = SH_HALF;
      default: quad_shift = SH_FULL;
    endcase
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// Parametrised carry-lookahead adder: generate/propagate per bit, carries
// resolved from the lookahead recurrence.
module cla_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/vedic_mul_core.sv
// Combinational N x N Urdhva-Tiryagbhyam multiplier, built recursively from
// four N/2 cores down to a 2x2 base cell; partial sums use cla_nbit.
module vedic_mul_core #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_base
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_rec
    localparam int H = N / 2;

    logic [N-1:0]   p_ll;
    logic [N-1:0]   p_lh;
    logic [N-1:0]   p_hl;
    logic [N-1:0]   p_hh;
    logic [2*N-1:0] s1;
    logic           c1_unused;
    logic           c2_unused;

    vedic_mul_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(p_ll));
    vedic_mul_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(p_lh));
    vedic_mul_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(p_hl));
    vedic_mul_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(p_hh));

    // Outer terms do not overlap, so they concatenate; cross terms are added.
    cla_nbit #(.WIDTH(2*N)) u_s1 (
      .a    ({p_hh, p_ll}),
      .b    ({{H{1'b0}}, p_lh, {H{1'b0}}}),
      .cin  (1'b0),
      .sum  (s1),
      .cout (c1_unused)
    );

    cla_nbit #(.WIDTH(2*N)) u_s2 (
      .a    (s1),
      .b    ({{H{1'b0}}, p_hl, {H{1'b0}}}),
      .cin  (1'b0),
      .sum  (p),
      .cout (c2_unused)
    );
  end

endmodule

// File: rtl/vedic_mul_seq.sv
// Multi-cycle WIDTH x WIDTH Vedic multiplier: one shared HALF x HALF core is
// stepped over four quadrants. Optional signed mode: VEDIC_MUL_SIGNED_EN.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VEDIC_MUL_SIGNED_EN
  input  logic               signed_mode,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; m is held stable while out_valid is high and out_ready is low.
  state_t           state;
  quad_t            q;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    acc;
  logic [HALF-1:0]  core_a;
  logic [HALF-1:0]  core_b;
  logic [WIDTH-1:0] core_p;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    acc_final;
  logic             acc_cout_unused;
  logic             accept;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign m        = acc;

  always_comb begin
    core_a = a_r[HALF-1:0];
    core_b = b_r[HALF-1:0];
    case (q)
      Q_LO_LO: begin core_a = a_r[HALF-1:0];     core_b = b_r[HALF-1:0];     end
      Q_LO_HI: begin core_a = a_r[HALF-1:0];     core_b = b_r[WIDTH-1:HALF]; end
      Q_HI_LO: begin core_a = a_r[WIDTH-1:HALF]; core_b = b_r[HALF-1:0];     end
      default: begin core_a = a_r[WIDTH-1:HALF]; core_b = b_r[WIDTH-1:HALF]; end
    endcase
  end

  vedic_mul_core #(.N(HALF)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_comb begin
    addend = '0;
    case (quad_shift(q))
      SH_ZERO: addend = {{WIDTH{1'b0}}, core_p};
      SH_HALF: addend = {{HALF{1'b0}}, core_p, {HALF{1'b0}}};
      SH_FULL: addend = {core_p, {WIDTH{1'b0}}};
      default: addend = '0;
    endcase
  end

  // Product of two WIDTH-bit magnitudes never exceeds PW bits, so cout is 0.
  cla_nbit #(.WIDTH(PW)) u_acc_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_cout_unused)
  );

`ifdef VEDIC_MUL_SIGNED_EN
  logic neg;
  assign acc_final = neg ? -acc_sum : acc_sum;
`else
  assign acc_final = acc_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= Q_LO_LO;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef VEDIC_MUL_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else if (accept) begin
      state     <= MUL;
      q         <= Q_LO_LO;
      acc       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
`ifdef VEDIC_MUL_SIGNED_EN
      // Core works on magnitudes; the sign is reapplied on the last add.
      a_r <= (signed_mode & a[WIDTH-1]) ? -a : a;
      b_r <= (signed_mode & b[WIDTH-1]) ? -b : b;
      neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
      a_r <= a;
      b_r <= b;
`endif
    end else begin
      case (state)
        MUL: begin
          q <= q + 2'd1;
          if (q == Q_HI_HI) begin
            acc       <= acc_final;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            acc <= acc_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
